// File: rtl/approx_mul_pkg.sv
// rtl/approx_mul_pkg.sv - shared types and parameter checks for the approximate multiplier
// Contents:
//   mode_e       : per-beat arithmetic mode (exact / approximate)
//   params_legal : elaboration-time legality check of the multiplier parameters
package approx_mul_pkg;

   typedef enum logic {
      MODE_EXACT  = 1'b0,
      MODE_APPROX = 1'b1
   } mode_e;

   function automatic bit params_legal(int w, int l, int k, int tag_w, int cnt_w);
      return (w >= 4) && (w <= 32) &&
             (l >= 0) && (l <= w) &&
             (k >= 0) && (k <= 2 * w - 1) &&
             (tag_w >= 1) && (cnt_w >= 1);
   endfunction

endpackage

// File: rtl/approx_low_array.sv
// rtl/approx_low_array.sv - combinational OR-compressed, column-truncated low partial-product array
// Ports:
//   x   : in,  low multiplier bits x[L-1:0] (one dummy bit when L=0)
//   y   : in,  multiplicand
//   low : out, LOW term (2W bits)
module approx_low_array
   import approx_mul_pkg::*;
#(
   parameter int W = 8,
   parameter int L = 6,
   parameter int K = 6,
   localparam int XW = (L > 0) ? L : 1
) (
   input  logic [XW-1:0]  x,
   input  logic [W-1:0]   y,
   output logic [2*W-1:0] low
);

   localparam int PW = 2 * W;
   // Keeps product columns K and above.
   localparam logic [PW-1:0] KMASK = {PW{1'b1}} << K;

   // Rows are taken in pairs; a pair is OR-ed instead of added, an odd
   // trailing row stands alone. Each contribution is truncated below K.
   always_comb begin
      logic [PW-1:0] pair;
      pair = '0;
      low  = '0;
      for (int j = 0; j < L; j += 2) begin
         pair = '0;
         for (int i = j; (i < j + 2) && (i < L); i++) begin
            if (x[i]) begin
               pair = pair | (PW'(y) << i);
            end
         end
         low = low + (pair & KMASK);
      end
   end

endmodule

// File: rtl/approx_mul_pipe.sv
// rtl/approx_mul_pipe.sv - 3-stage valid/ready approximate/exact unsigned multiplier
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand beat handshake
//   in_x, in_y            : multiplier, multiplicand (W bits)
//   in_approx, in_tag     : per-beat mode select and opaque tag
//   out_valid/out_ready   : result handshake
//   out_z, out_tag        : product (2W bits) and returned tag
//   out_approx            : mode the result was computed in
//   approx_cnt, cnt_clr   : saturating count of delivered approximate results, sync clear
module approx_mul_pipe
   import approx_mul_pkg::*;
#(
   parameter int W     = 8,
   parameter int L     = 6,
   parameter int K     = 6,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_x,
   input  logic [W-1:0]       in_y,
   input  logic               in_approx,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*W-1:0]     out_z,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_approx,
   output logic [CNT_W-1:0]   approx_cnt,
   input  logic               cnt_clr
);

   localparam int PW = 2 * W;
   localparam int XW = (L > 0) ? L : 1;
   // Clearing the low L bits of x and multiplying equals (y * x[W-1:L]) << L,
   // and stays well-formed for L=0 and L=W.
   localparam logic [W-1:0]     HMASK   = {W{1'b1}} << L;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (!params_legal(W, L, K, TAG_W, CNT_W)) begin : g_bad_params
      $error("approx_mul_pipe: illegal parameter combination");
   end

   // Global stall: every stage moves only when the output slot is free or drained.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // S1: operand register
   logic             s1_valid;
   logic [W-1:0]     s1_x;
   logic [W-1:0]     s1_y;
   mode_e            s1_mode;
   logic [TAG_W-1:0] s1_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_mode  <= MODE_EXACT;
         s1_tag   <= '0;
      end else if (advance) begin
         s1_valid <= in_valid;
         s1_x     <= in_x;
         s1_y     <= in_y;
         s1_mode  <= in_approx ? MODE_APPROX : MODE_EXACT;
         s1_tag   <= in_tag;
      end
   end

   // S2: partial products into HIGH and LOW
   logic [PW-1:0] low_term;
   logic [PW-1:0] high_term;

   approx_low_array #(
      .W (W),
      .L (L),
      .K (K)
   ) u_low (
      .x   (s1_x[XW-1:0]),
      .y   (s1_y),
      .low (low_term)
   );

   always_comb begin
      high_term = '0;
      if (s1_mode == MODE_APPROX) begin
         high_term = PW'(s1_y) * PW'(s1_x & HMASK);
      end else begin
         high_term = PW'(s1_y) * PW'(s1_x);
      end
   end

   logic             s2_valid;
   logic [PW-1:0]    s2_high;
   logic [PW-1:0]    s2_low;
   mode_e            s2_mode;
   logic [TAG_W-1:0] s2_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_high  <= '0;
         s2_low   <= '0;
         s2_mode  <= MODE_EXACT;
         s2_tag   <= '0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_high  <= high_term;
         s2_low   <= (s1_mode == MODE_APPROX) ? low_term : '0;
         s2_mode  <= s1_mode;
         s2_tag   <= s1_tag;
      end
   end

   // S3: final addition into the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_z      <= '0;
         out_tag    <= '0;
         out_approx <= 1'b0;
      end else if (advance) begin
         out_valid  <= s2_valid;
         out_z      <= s2_high + s2_low;
         out_tag    <= s2_tag;
         out_approx <= (s2_mode == MODE_APPROX);
      end
   end

   // Clear has priority over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         approx_cnt <= '0;
      end else if (cnt_clr) begin
         approx_cnt <= '0;
      end else if (out_valid && out_ready && out_approx && (approx_cnt != CNT_MAX)) begin
         approx_cnt <= approx_cnt + 1'b1;
      end
   end

endmodule

// File: doc/approx_mul_pipe.md
# approx_mul_pipe

Pipelined, parametrised unsigned approximate multiplier with a valid/ready stream interface and per-transaction exact/approximate mode select. It generalises the fixed 8x8 approximate multipliers to any operand width, approximation depth and truncation column. It adds backpressure, tag passthrough and an approximate-operation counter. It sits between operand producers and accumulator or datapath consumers in the approximate-arithmetic library.

## Interface
- `W`, default 8: operand width; legal range 4..32.
- `L`, default 6: approximation depth, meaning the number of low multiplier rows (x bits) handled approximately; legal range 0..W.
- `K`, default 6: truncation column; product columns below K are dropped in the approximate low part; legal range 0..2W-1.
- `TAG_W`, default 4: sideband tag width, at least 1.
- `CNT_W`, default 16: approximate-operation counter width.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operand beat valid.
- `in_ready`, output, 1: block accepts a beat this cycle.
- `in_x`, input, W: multiplier.
- `in_y`, input, W: multiplicand.
- `in_approx`, input, 1: 1 selects approximate mode; 0 selects the exact product.
- `in_tag`, input, TAG_W: opaque; returned unchanged with the result.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_z`, output, 2W: product.
- `out_tag`, output, TAG_W: tag of this result.
- `out_approx`, output, 1: mode this result was computed in.
- `approx_cnt`, output, CNT_W: count of approximate results delivered; saturating.
- `cnt_clr`, input, 1: synchronous clear of `approx_cnt`.

## Operation
- Exact mode: `out_z` = `in_x` * `in_y`, full 2W bits.
- Approximate mode: `out_z` = (`in_y` * `in_x`[W-1:L]) << L, plus LOW, truncated to 2W bits.
  - Define pp_i = (`in_y` << i) if `in_x`[i] is 1, else 0, for i < L.
  - Pair rows (0,1), (2,3), … Each pair contributes (pp_2j | pp_2j+1), i.e. an OR-compressor replacing the sum.
  - If L is odd, the last row is contributed alone.
  - Each contribution is masked to columns ≥ K before the sum.
  - LOW is the sum of the contributions.
- L=0 makes approximate mode equal exact mode. If `in_x`[L-1:0] is 0, the approximate result equals the exact result.
- `approx_cnt` increments by 1 on each output handshake with `out_approx`=1 and saturates at 2^CNT_W-1.
- `cnt_clr` wins over a simultaneous increment; the counter reads 0 on the next cycle.

## Timing
- Three-stage pipeline:
  - S1 registers the operands.
  - S2 generates and compresses partial products into the HIGH and LOW terms.
  - S3 performs the final addition into the output register.
- Latency is 3 cycles from input handshake to `out_valid`, with no bubbles.
- Throughput is 1 result per cycle while `out_ready`=1.
- Stage advance: advance = !S3_valid || `out_ready`. All stages move together; `in_ready` = advance, with no combinational path from `in_valid` to `in_ready`.
- Handshake occurs when valid and ready are both 1 on a rising edge.
- While stalled (`out_valid`=1, `out_ready`=0), `out_z`, `out_tag` and `out_approx` hold stable. `in_ready`=0 and no beat is lost or duplicated.
- Bubbles (invalid slots) inside the pipeline are not squeezed out while stalled; the simple global-stall design is required.
- Reset (asserted asynchronously at any time, including mid-stream): all stage valid bits, `out_valid` and `approx_cnt` clear to 0. `out_z` and `out_tag` reset to 0 and `out_approx` resets to 0. In-flight beats are discarded.
- `in_ready` is 1 on the first cycle after reset deassertion.

## Structure
- Package `approx_mul_pkg`: `mode_e` enum (MODE_EXACT=0, MODE_APPROX=1), and a parameter-legality check function used by an elaboration-time assertion.
- Sub-module `approx_low_array` (parameters W, L, K): purely combinational. It produces the LOW term from x[L-1:0] and y, and is instantiated inside S2. It is reusable by future non-pipelined variants.
- The top level holds the pipeline registers, valid/stall control and the counter.

## Test plan
- W=8, L=6, K=6, x=8'hFF, y=8'hFF, one beat in each mode:
  - Exact beat gives `out_z`=65025.
  - Approximate beat gives `out_z`=59520 (HIGH 48960 + LOW 448+1984+8128).
  - Each result arrives 3 cycles after its handshake.
- x=8'h40, y=8'hC8, approximate mode: `out_z`=12800, equal to exact. Also x=0 with random y gives 0 in both modes.
- Back-to-back stream of 20 random beats with random `out_ready` stalls:
  - Results match a reference model in order, with tags preserved.
  - Outputs stay stable during every stall.
  - `approx_cnt` equals the number of delivered approximate beats.
- Assert `rst_n` low with 3 beats in flight: `out_valid` drops to 0 immediately and `approx_cnt`=0. After release, the next beat's result appears after 3 cycles with no stale data.
- CNT_W=4: deliver 20 approximate beats and the counter saturates at 15. Then pulse `cnt_clr` in the same cycle as an approximate handshake: the counter reads 0.
- Sweep W=16, L in {0,5,16}, K in {0,10}: 1000 random beats each match the model. L=0 shows the approximate result equal to the exact result.
